// File: rtl/lsu_ctrl_if.sv
// Load/store unit bus bundle: pipeline request side plus data-memory side.
// master: the LSU itself. slave: the surrounding pipeline/memory environment.
interface lsu_ctrl_if;
  // Pipeline request (EX/MEM register)
  logic        mem_req;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] st_data;
  // Data memory bus
  logic        dm_cs;
  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [3:0]  dm_mask;
  logic [31:0] dm_wdata;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  // Pipeline response
  logic        lsu_stall;
  logic        done;
  logic [31:0] load_data;
  logic        lsu_err;
  logic [1:0]  err_code;

  modport master (
    input  mem_req, is_store, funct3, addr, st_data, dm_valid, dm_rdata,
    output dm_cs, dm_wr, dm_addr, dm_mask, dm_wdata,
           lsu_stall, done, load_data, lsu_err, err_code
  );

  modport slave (
    output mem_req, is_store, funct3, addr, st_data, dm_valid, dm_rdata,
    input  dm_cs, dm_wr, dm_addr, dm_mask, dm_wdata,
           lsu_stall, done, load_data, lsu_err, err_code
  );
endinterface

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store unit in front of a word-addressed data memory.
// Aligns/replicates store data, extracts and extends load data, stalls the
// pipeline until the memory answers, times out, or a fault is detected.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned H/W accesses with
// code 01 instead of forcing the offset down).
module lsu_ctrl #(
  parameter int WORD_ADDR_W    = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  lsu_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             err_q, err_d;
  logic [31:0]            load_q, load_d;

  logic                   store_q;
  logic [2:0]             f3_q;
  logic [WORD_ADDR_W+1:0] addr_q;
  logic [31:0]            sdata_q;

  logic                   bad_f3, out_rng, misal;
  logic [1:0]             fault;
  logic [1:0]             off_eff;

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  // Fault classification of the incoming request
  always_comb begin
    bad_f3  = 1'b0;
    case (bus.funct3)
      3'b000, 3'b001, 3'b010: bad_f3 = 1'b0;
      3'b100, 3'b101:         bad_f3 = bus.is_store;
      default:                bad_f3 = 1'b1;
    endcase
    out_rng = |bus.addr[31:WORD_ADDR_W+2];
`ifdef MISALIGN_TRAP_EN
    misal   = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
              ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
    misal   = 1'b0;
`endif
    if (bad_f3 || out_rng) fault = 2'b10;
    else if (misal)        fault = 2'b01;
    else                   fault = 2'b00;
  end

  // Effective lane offset: halfwords and words are forced to their natural boundary
  always_comb begin
    case (f3_q[1:0])
      2'b00:   off_eff = addr_q[1:0];
      2'b01:   off_eff = {addr_q[1], 1'b0};
      default: off_eff = 2'b00;
    endcase
  end

  // Request capture when a new access is accepted
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.mem_req) begin
      store_q <= bus.is_store;
      f3_q    <= bus.funct3;
      addr_q  <= bus.addr[WORD_ADDR_W+1:0];
      sdata_q <= bus.st_data;
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 2'b00;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

  // Next-state and memory/pipeline outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    load_d        = load_q;
    bus.dm_cs     = 1'b1;
    bus.dm_wr     = 1'b1;
    bus.dm_addr   = '0;
    bus.dm_mask   = 4'b0000;
    bus.dm_wdata  = '0;
    bus.lsu_stall = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.mem_req) begin
          bus.lsu_stall = 1'b1;
          err_d         = fault;
          state_d       = (fault == 2'b00) ? REQ : RESP;
        end
      end
      REQ: begin
        bus.lsu_stall = 1'b1;
        bus.dm_cs     = 1'b0;
        bus.dm_wr     = ~store_q;
        bus.dm_addr   = 32'(addr_q[WORD_ADDR_W+1:2]);
        if (store_q) begin
          bus.dm_mask  = lane_mask(f3_q, off_eff);
          bus.dm_wdata = lane_wdata(f3_q, sdata_q);
        end
        if (bus.dm_valid) begin
          if (!store_q) load_d = load_ext(f3_q, off_eff, bus.dm_rdata);
          cnt_d   = '0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 2'b11;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.done      = (state_q == RESP);
  assign bus.lsu_err   = (state_q == RESP) && (err_q != 2'b00);
  assign bus.err_code  = err_q;
  assign bus.load_data = load_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, multi-cycle
// sequences (timeout, reset mid-access) and randomized accesses against a
// behavioural model of the load/store rules.
module tb_lsu_ctrl;
  localparam int WAW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_ctrl_if bus();

  lsu_ctrl #(.WORD_ADDR_W(WAW), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          delay;
    logic [1:0]  code;
    logic [31:0] waddr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] load;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [31:0] cur_load;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata, input int delay,
                              input logic [1:0] code, input logic [31:0] waddr, input logic [3:0] mask,
                              input logic [31:0] wdata, input logic [31:0] load);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.delay = delay;
    v.code = code; v.waddr = waddr; v.mask = mask; v.wdata = wdata; v.load = load;
    return v;
  endfunction

  // Behavioural reference: derives expectations from access size and byte offset
  function automatic vec_t model(input vec_t v, input logic [31:0] prev_load);
    vec_t r;
    int size, off;
    logic bad, mis;
    logic [31:0] val, lim;
    r = v;
    bad = v.st ? (v.f3 > 3'd2) : !(v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    bad = bad || (v.addr >= (32'd1 << (WAW + 2)));
    size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    mis = (v.addr % size) != 0;
`ifndef MISALIGN_TRAP_EN
    mis = 1'b0;
`endif
    if (bad)                r.code = 2'd2;
    else if (mis)           r.code = 2'd1;
    else if (v.delay >= 16) r.code = 2'd3;
    else                    r.code = 2'd0;
    off = (v.addr % 4) - ((v.addr % 4) % size);
    r.waddr = v.addr / 4;
    r.mask = 4'b0000;
    r.wdata = 32'h0;
    if (v.st) begin
      r.mask = 4'(((1 << size) - 1) << off);
      if (size == 1)      r.wdata = (v.sdata & 32'hFF) * 32'h01010101;
      else if (size == 2) r.wdata = (v.sdata & 32'hFFFF) * 32'h00010001;
      else                r.wdata = v.sdata;
    end
    r.load = prev_load;
    if (!v.st && r.code == 2'd0) begin
      if (size == 4) val = v.rdata;
      else begin
        lim = (32'd1 << (8 * size));
        val = (v.rdata >> (8 * off)) % lim;
        if (!v.f3[2] && val >= lim / 2) val = val - lim;
      end
      r.load = val;
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int cyc, cs_cnt, done_cyc, exp_cs, exp_done;
    logic s_wr, s_err, s_stall, stall_bad;
    logic [31:0] s_addr, s_wdata, s_load;
    logic [3:0] s_mask;
    logic [1:0] s_code;
    exp_cs   = (v.code == 2'd0) ? ((v.delay < 15 ? v.delay : 15) + 1) : (v.code == 2'd3 ? 16 : 0);
    exp_done = (exp_cs > 0) ? exp_cs + 1 : 1;
    s_wr = 1'b1; s_addr = '0; s_wdata = '0; s_mask = '0;
    s_code = '0; s_err = 1'b0; s_load = '0; s_stall = 1'b1; stall_bad = 1'b0;
    bus.mem_req = 1'b1; bus.is_store = v.st; bus.funct3 = v.f3;
    bus.addr = v.addr; bus.st_data = v.sdata; bus.dm_rdata = v.rdata; bus.dm_valid = 1'b0;
    #1;
    if (bus.lsu_stall !== 1'b1) stall_bad = 1'b1;
    cyc = 0; cs_cnt = 0; done_cyc = 0;
    while (done_cyc == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.dm_cs == 1'b0) begin
        if (cs_cnt == 0) begin
          s_wr = bus.dm_wr; s_addr = bus.dm_addr; s_mask = bus.dm_mask; s_wdata = bus.dm_wdata;
        end
        cs_cnt++;
        if (bus.lsu_stall !== 1'b1) stall_bad = 1'b1;
        bus.dm_valid = ((cs_cnt - 1) == v.delay);
        bus.addr = $urandom;
        bus.st_data = $urandom;
      end else begin
        bus.dm_valid = 1'b0;
      end
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        s_code = bus.err_code; s_err = bus.lsu_err; s_load = bus.load_data; s_stall = bus.lsu_stall;
      end
    end
    bus.mem_req = 1'b0;
    bus.dm_valid = 1'b0;
    @(negedge clk);
    chk({tag, " done_cycle"}, done_cyc, exp_done);
    chk({tag, " cs_cycles"}, cs_cnt, exp_cs);
    chk({tag, " stall_busy"}, {31'b0, stall_bad}, 32'd0);
    if (exp_cs > 0) begin
      chk({tag, " dm_wr"}, {31'b0, s_wr}, {31'b0, ~v.st});
      chk({tag, " dm_addr"}, s_addr, v.waddr);
      chk({tag, " dm_mask"}, {28'b0, s_mask}, {28'b0, v.mask});
      if (v.st) chk({tag, " dm_wdata"}, s_wdata, v.wdata);
    end
    chk({tag, " err_code"}, {30'b0, s_code}, {30'b0, v.code});
    chk({tag, " lsu_err"}, {31'b0, s_err}, {31'b0, (v.code != 2'd0)});
    chk({tag, " load_data"}, s_load, v.load);
    chk({tag, " stall_at_done"}, {31'b0, s_stall}, 32'd0);
  endtask

  vec_t tbl[13];

  initial begin
    vec_t v;
    logic [2:0] f3s[7];
    logic saw_done, cs_low;
    f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd2; f3s[3] = 3'd4;
    f3s[4] = 3'd5; f3s[5] = 3'd3; f3s[6] = 3'd6;

    tbl[0]  = mk(1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0,  2'd0, 32'd4, 4'b1111, 32'hDEADBEEF, 32'h0);
    tbl[1]  = mk(1, 3'b000, 32'h13,   32'h000000A5, 32'h0,        0,  2'd0, 32'd4, 4'b1000, 32'hA5A5A5A5, 32'h0);
    tbl[2]  = mk(0, 3'b000, 32'h11,   32'h0,        32'h0000F000, 0,  2'd0, 32'd4, 4'b0000, 32'h0, 32'hFFFFFFF0);
    tbl[3]  = mk(0, 3'b100, 32'h11,   32'h0,        32'h0000F000, 1,  2'd0, 32'd4, 4'b0000, 32'h0, 32'h000000F0);
    tbl[4]  = mk(0, 3'b001, 32'h12,   32'h0,        32'h80010000, 0,  2'd0, 32'd4, 4'b0000, 32'h0, 32'hFFFF8001);
    tbl[5]  = mk(0, 3'b010, 32'h1000, 32'h0,        32'h0,        0,  2'd2, 32'd0, 4'b0000, 32'h0, 32'hFFFF8001);
    tbl[6]  = mk(1, 3'b001, 32'h16,   32'h0000BEEF, 32'h0,        3,  2'd0, 32'd5, 4'b1100, 32'hBEEFBEEF, 32'hFFFF8001);
    tbl[7]  = mk(0, 3'b101, 32'h22,   32'h0,        32'hABCD1234, 2,  2'd0, 32'd8, 4'b0000, 32'h0, 32'h0000ABCD);
    tbl[8]  = mk(1, 3'b100, 32'h20,   32'h12345678, 32'h0,        0,  2'd2, 32'd0, 4'b0000, 32'h0, 32'h0000ABCD);
    tbl[9]  = mk(0, 3'b011, 32'h20,   32'h0,        32'h0,        0,  2'd2, 32'd0, 4'b0000, 32'h0, 32'h0000ABCD);
    tbl[10] = mk(0, 3'b010, 32'h20,   32'h0,        32'h11111111, 20, 2'd3, 32'd8, 4'b0000, 32'h0, 32'h0000ABCD);
`ifdef MISALIGN_TRAP_EN
    tbl[11] = mk(0, 3'b010, 32'h12,   32'h0,        32'h12345678, 0,  2'd1, 32'd0, 4'b0000, 32'h0, 32'h0000ABCD);
    tbl[12] = mk(1, 3'b001, 32'h15,   32'h00001234, 32'h0,        0,  2'd1, 32'd0, 4'b0000, 32'h0, 32'h0000ABCD);
`else
    tbl[11] = mk(0, 3'b010, 32'h12,   32'h0,        32'h12345678, 0,  2'd0, 32'd4, 4'b0000, 32'h0, 32'h12345678);
    tbl[12] = mk(1, 3'b001, 32'h15,   32'h00001234, 32'h0,        0,  2'd0, 32'd5, 4'b0011, 32'h12341234, 32'h12345678);
`endif

    // Reset state
    rst = 1'b0;
    bus.mem_req = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'b0; bus.addr = '0;
    bus.st_data = '0; bus.dm_valid = 1'b0; bus.dm_rdata = '0;
    #12;
    chk("rst dm_cs", {31'b0, bus.dm_cs}, 32'd1);
    chk("rst dm_wr", {31'b0, bus.dm_wr}, 32'd1);
    chk("rst dm_addr", bus.dm_addr, 32'd0);
    chk("rst dm_mask", {28'b0, bus.dm_mask}, 32'd0);
    chk("rst dm_wdata", bus.dm_wdata, 32'd0);
    chk("rst done", {31'b0, bus.done}, 32'd0);
    chk("rst load_data", bus.load_data, 32'd0);
    chk("rst lsu_err", {31'b0, bus.lsu_err}, 32'd0);
    chk("rst err_code", {30'b0, bus.err_code}, 32'd0);
    chk("rst stall", {31'b0, bus.lsu_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    cur_load = tbl[12].load;

    // Reset in the middle of a memory access
    bus.mem_req = 1'b1; bus.is_store = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h40;
    bus.dm_valid = 1'b0;
    cs_low = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.dm_cs !== 1'b0) cs_low = 1'b0;
    end
    chk("midrst cs_low_before", {31'b0, cs_low}, 32'd1);
    bus.mem_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst dm_cs", {31'b0, bus.dm_cs}, 32'd1);
    chk("midrst stall", {31'b0, bus.lsu_stall}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    chk("midrst no_done", {31'b0, saw_done}, 32'd0);
    chk("midrst load_data", bus.load_data, 32'd0);
    chk("midrst err_code", {30'b0, bus.err_code}, 32'd0);
    cur_load = 32'h0;

    // Randomized accesses against the reference model
    for (int n = 0; n < 40; n++) begin
      v.st    = 1'($urandom_range(0, 1));
      v.f3    = ($urandom_range(0, 9) == 0) ? f3s[$urandom_range(5, 6)] : f3s[$urandom_range(0, 4)];
      v.addr  = $urandom_range(0, 4095);
      if ($urandom_range(0, 7) == 0) v.addr = v.addr | (32'd1 << $urandom_range(12, 31));
      v.sdata = $urandom;
      v.rdata = $urandom;
      v.delay = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
      v = model(v, cur_load);
      run_vec(v, $sformatf("rnd%0d", n));
      cur_load = v.load;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
